// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: channel registers and dwell-timed CD select sweeper for a 4:1 mux; define SCAN_MASK_EN to add chan_mask channel skipping
module mux_scan_sequencer #(
  parameter int DWELL = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [1:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic          cont,
`ifdef SCAN_MASK_EN
  input  logic [3:0]    chan_mask,
`endif
  output logic [DW-1:0] I0,
  output logic [DW-1:0] I1,
  output logic [DW-1:0] I2,
  output logic [DW-1:0] I3,
  output logic [1:0]    CD,
  output logic          busy,
  output logic          scan_done
);
  localparam int CW = $clog2(DWELL) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] ch [4];
  logic [3:0] mask;
  logic [3:0] start_mask;
  logic dwell_end, at_end;
`ifdef SCAN_MASK_EN
  assign start_mask = chan_mask;
`else
  assign start_mask = 4'hf;
  assign mask = 4'hf;
`endif
  function automatic logic [1:0] first_of(input logic [3:0] m);
    first_of = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) first_of = 2'(i);
  endfunction
  function automatic logic [1:0] last_of(input logic [3:0] m);
    last_of = 2'd0;
    for (int i = 0; i < 4; i++) if (m[i]) last_of = 2'(i);
  endfunction
  function automatic logic [1:0] next_of(input logic [3:0] m, input logic [1:0] c);
    next_of = first_of(m);
    for (int i = 3; i >= 0; i--) if (m[i] && 2'(i) > c) next_of = 2'(i);
  endfunction
  assign dwell_end = cnt == CNT_LAST;
  assign at_end = dwell_end && CD == last_of(mask);
  assign busy = state == SCAN;
  assign scan_done = busy && at_end && !cont && !stop;
  assign I0 = ch[0];
  assign I1 = ch[1];
  assign I2 = ch[2];
  assign I3 = ch[3];
  // channel registers: writable in any state, independent of the sweep
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 4; i++) ch[i] <= '0;
    else if (wr_en) ch[wr_addr] <= wr_data;
  // sweep FSM: dwell counting, select advance, wrap and termination
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      CD <= 2'd0;
      cnt <= '0;
`ifdef SCAN_MASK_EN
      mask <= 4'd0;
`endif
    end else if (state == IDLE) begin
      if (start && |start_mask) begin
        state <= SCAN;
        CD <= first_of(start_mask);
        cnt <= '0;
`ifdef SCAN_MASK_EN
        mask <= start_mask;
`endif
      end
    end else if (stop) begin
      state <= IDLE;
      CD <= 2'd0;
      cnt <= '0;
    end else if (!dwell_end) cnt <= cnt + 1'b1;
    else begin
      cnt <= '0;
      if (!at_end) CD <= next_of(mask, CD);
      else if (cont) CD <= first_of(mask);
      else begin
        state <= IDLE;
        CD <= 2'd0;
      end
    end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed scoreboard bench for mux_scan_sequencer
module tb_mux_scan_sequencer;
  localparam int DWELL = 4;
  localparam int DW = 4;
  logic clk = 0, rst_n = 1, wr_en = 0, start = 0, stop = 0, cont = 0;
  logic [1:0] wr_addr = 0;
  logic [DW-1:0] wr_data = 0;
`ifdef SCAN_MASK_EN
  logic [3:0] chan_mask = 4'hf;
`endif
  logic [DW-1:0] I0, I1, I2, I3, sel;
  logic [1:0] CD;
  logic busy, scan_done;
  int checks = 0, errors = 0;
  logic [DW-1:0] mem [4];
  logic [3:0] q [$];

  mux_scan_sequencer #(.DWELL(DWELL), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .cont(cont),
`ifdef SCAN_MASK_EN
    .chan_mask(chan_mask),
`endif
    .I0(I0), .I1(I1), .I2(I2), .I3(I3), .CD(CD), .busy(busy), .scan_done(scan_done)
  );

  always #5 clk = ~clk;
  always_comb sel = CD == 2'd0 ? I0 : CD == 2'd1 ? I1 : CD == 2'd2 ? I2 : I3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_sweep(input logic [3:0] m, input bit done_last);
    int hi = 0;
    for (int c = 0; c < 4; c++) if (m[c]) hi = c;
    for (int c = 0; c < 4; c++)
      if (m[c])
        for (int k = 0; k < DWELL; k++)
          q.push_back({2'(c), 1'b1, done_last && c == hi && k == DWELL - 1});
  endtask

  task automatic chk_next;
    logic [3:0] e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: observed empty queue, expected an entry");
    end else begin
      e = q.pop_front();
      chk("cd", CD, e[3:2]);
      chk("busy", busy, e[1]);
      chk("scan_done", scan_done, e[0]);
      chk("mux_data", sel, mem[e[3:2]]);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cd"}, CD, 0);
    chk({tag, "_done"}, scan_done, 0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [DW-1:0] d);
    wr_en = 1;
    wr_addr = a;
    wr_data = d;
    tick;
    wr_en = 0;
    mem[a] = d;
  endtask

  task automatic pulse_start;
    start = 1;
    tick;
    start = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    #1 rst_n = 0;
    repeat (3) tick;
    chk("rst_I0", I0, 0);
    chk("rst_I1", I1, 0);
    chk("rst_I2", I2, 0);
    chk("rst_I3", I3, 0);
    idle_chk("rst");
    rst_n = 1;
    tick;
    wr(2'd0, 4'h3);
    wr(2'd1, 4'h7);
    wr(2'd2, 4'hA);
    wr(2'd3, 4'hF);
    chk("wr_I0", I0, 4'h3);
    chk("wr_I1", I1, 4'h7);
    chk("wr_I2", I2, 4'hA);
    chk("wr_I3", I3, 4'hF);
    push_sweep(4'hf, 1);
    pulse_start;
    for (int i = 1; i <= 16; i++) begin
      chk_next;
      start = i == 5;
      tick;
    end
    start = 0;
    idle_chk("single_end");
    cont = 1;
    push_sweep(4'hf, 0);
    push_sweep(4'hf, 1);
    pulse_start;
    for (int i = 1; i <= 32; i++) begin
      chk_next;
      if (i == 17) cont = 0;
      tick;
    end
    idle_chk("cont_end");
    for (int i = 0; i < 6; i++) q.push_back({i < 4 ? 2'd0 : 2'd1, 1'b1, 1'b0});
    pulse_start;
    for (int i = 1; i <= 6; i++) begin
      chk_next;
      if (i == 6) stop = 1;
      tick;
    end
    chk("stop_done_seen", scan_done, 0);
    stop = 0;
    idle_chk("stop");
    tick;
    idle_chk("stop_hold");
    push_sweep(4'hf, 1);
    start = 1;
    stop = 1;
    tick;
    start = 0;
    stop = 0;
    for (int i = 1; i <= 16; i++) begin
      chk_next;
      tick;
    end
    idle_chk("restart_end");
    push_sweep(4'hf, 1);
    pulse_start;
    for (int i = 1; i <= 16; i++) begin
      chk_next;
      if (i == 10) begin
        wr_en = 1;
        wr_addr = 2'd2;
        wr_data = 4'h5;
      end
      tick;
      if (i == 10) begin
        wr_en = 0;
        mem[2] = 4'h5;
        chk("mid_write_I2", I2, 4'h5);
      end
    end
    idle_chk("mid_write_end");
    pulse_start;
    tick;
    chk("pre_areset_busy", busy, 1);
    chk("pre_areset_cd", CD, 0);
    rst_n = 0;
    #1;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    idle_chk("areset");
    chk("areset_I0", I0, 0);
    chk("areset_I2", I2, 0);
    chk("areset_I3", I3, 0);
    @(negedge clk);
    rst_n = 1;
    tick;
    idle_chk("areset_release");
`ifdef SCAN_MASK_EN
    wr(2'd1, 4'h6);
    wr(2'd3, 4'h9);
    chan_mask = 4'b1010;
    push_sweep(4'b1010, 1);
    pulse_start;
    for (int i = 1; i <= 2 * DWELL; i++) begin
      chk_next;
      tick;
    end
    idle_chk("mask_end");
    chan_mask = 4'b0000;
    pulse_start;
    idle_chk("mask_zero");
    chan_mask = 4'hf;
`endif
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
